// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment encodings, the digit-to-segment helper and the
// conversion FSM state type for the scanned 7-segment driver.
// Segment bytes are active-low, bit order {dp,g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hD8, 8'h80, 8'h90
    };
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] DP_MASK   = 8'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_e;

    // Non-decimal nibbles render as blank rather than garbage.
    function automatic logic [7:0] seg7_code(input logic [3:0] v);
        logic [7:0] c;
        case (v)
            4'd0:    c = SEG_DIGIT[0];
            4'd1:    c = SEG_DIGIT[1];
            4'd2:    c = SEG_DIGIT[2];
            4'd3:    c = SEG_DIGIT[3];
            4'd4:    c = SEG_DIGIT[4];
            4'd5:    c = SEG_DIGIT[5];
            4'd6:    c = SEG_DIGIT[6];
            4'd7:    c = SEG_DIGIT[7];
            4'd8:    c = SEG_DIGIT[8];
            4'd9:    c = SEG_DIGIT[9];
            default: c = SEG_BLANK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble, one input bit per clock.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : accepted only in IDLE; captures bin
//   bin        : unsigned value to convert
//   busy       : high from the edge after start until the COMMIT edge
//   done       : one-cycle pulse while in COMMIT (bcd is final then)
//   bcd        : packed BCD result, digit k at [4k+3:4k]
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int BIN_W = 13,
    parameter int BCD_D = (BIN_W + 2) / 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BIN_W-1:0]     bin,
    output logic                 busy,
    output logic                 done,
    output logic [4*BCD_D-1:0]   bcd
);

    localparam int CW = $clog2(BIN_W + 1);

    conv_state_e            state_q, state_d;
    logic [BIN_W-1:0]       bin_q, bin_d;
    logic [4*BCD_D-1:0]     bcd_q, bcd_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [4*BCD_D-1:0]     adj;
    logic [4*BCD_D+BIN_W-1:0] sh;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;

        // Add-3 correction before the shift keeps each nibble decimal.
        adj = bcd_q;
        for (int k = 0; k < BCD_D; k++) begin
            if (adj[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
        end
        sh = {adj, bin_q} << 1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    bcd_d   = '0;
                    cnt_d   = CW'(BIN_W);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = sh;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = ST_COMMIT;
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_COMMIT);
    assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: binary value -> BCD (sequential) -> formatted digits,
// driven both as a time-multiplexed common-anode scan and a static bus.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bin_in     : value to display, captured on an accepted load
//   dp_in      : decimal points (bit i = digit i), captured with bin_in
//   load       : strobe; ignored while a conversion is in flight
//   blank_lz   : leading-zero blanking, sampled when the result commits
//   busy       : conversion in progress
//   overflow   : last committed value did not fit in DIGITS digits
//   seg_n/dig_n: scanned segments / one-hot digit select, active-low
//   seg_all    : static segments, digit i in byte i
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int BIN_W    = 13,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  overflow,
    output logic [7:0]            seg_n,
    output logic [DIGITS-1:0]     dig_n,
    output logic [8*DIGITS-1:0]   seg_all
);

    localparam int BCD_D = (BIN_W + 2) / 3;
    // Padded digit count so formatting never indexes past either range.
    localparam int PAD_D = (DIGITS > BCD_D) ? DIGITS : BCD_D;
    localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                   conv_busy, conv_done;
    logic [4*BCD_D-1:0]     bcd;
    logic [4*PAD_D-1:0]     bcd_pad;

    logic [DIGITS-1:0]          dp_q, dp_d;
    logic [DIGITS-1:0][7:0]     disp_q, disp_d, fmt;
    logic                       ovf_q, ovf_d, ovf;
    logic [PW-1:0]              presc_q, presc_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [7:0]                 seg_n_q, seg_n_d;
    logic [DIGITS-1:0]          dig_n_q, dig_n_d;
    logic                       wrap;
    logic                       lz;
    logic [3:0]                 nib;
    logic [7:0]                 code;

    bin2bcd_seq #(
        .BIN_W (BIN_W),
        .BCD_D (BCD_D)
    ) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (load),
        .bin   (bin_in),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Formatting of the finished BCD value.
    always_comb begin
        bcd_pad = '0;
        bcd_pad[4*BCD_D-1:0] = bcd;

        ovf = 1'b0;
        for (int k = 0; k < PAD_D; k++) begin
            if (k >= DIGITS && bcd_pad[4*k +: 4] != 4'd0)
                ovf = 1'b1;
        end

        // lz stays set while every digit from the top down to i is zero.
        lz   = 1'b1;
        fmt  = '0;
        nib  = '0;
        code = SEG_BLANK;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = bcd_pad[4*i +: 4];
            lz  = lz & (nib == 4'd0);
            if (ovf)
                code = SEG_DASH;
            else if (blank_lz && i > 0 && lz)
                code = SEG_BLANK;
            else
                code = seg7_code(nib);
            if (dp_q[i])
                code = code & DP_MASK;
            fmt[i] = code;
        end
    end

    // Capture, commit and scan.
    always_comb begin
        dp_d    = dp_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        seg_n_d = seg_n_q;
        dig_n_d = dig_n_q;

        if (load && !conv_busy)
            dp_d = dp_in;

        if (conv_done) begin
            disp_d = fmt;
            ovf_d  = ovf;
        end

        wrap = (presc_q == PW'(SCAN_DIV - 1));
        if (wrap) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
            seg_n_d = disp_q[idx_d];
            dig_n_d = ~(DIGITS'(1) << idx_d);
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_q    <= '0;
            disp_q  <= {DIGITS{SEG_BLANK}};
            ovf_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= IW'(DIGITS - 1);
            seg_n_q <= SEG_BLANK;
            dig_n_q <= '1;
        end else begin
            dp_q    <= dp_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_n_q <= seg_n_d;
            dig_n_q <= dig_n_d;
        end
    end

    assign busy     = conv_busy;
    assign overflow = ovf_q;
    assign seg_n    = seg_n_q;
    assign dig_n    = dig_n_q;
    assign seg_all  = disp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4-digit main instance plus a
// 3-digit instance that can actually overflow with a 13-bit input).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] bin_in = '0;
    logic [3:0]  dp_in = '0;
    logic [2:0]  dp2 = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b1;

    logic        busy, overflow;
    logic [7:0]  seg_n;
    logic [3:0]  dig_n;
    logic [31:0] seg_all;

    logic        busy2, overflow2;
    logic [7:0]  seg_n2;
    logic [2:0]  dig_n2;
    logic [23:0] seg_all2;

    int errors = 0;
    int checks = 0;
    int nb;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .BIN_W(13), .SCAN_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .dp_in(dp_in),
        .load(load), .blank_lz(blank_lz), .busy(busy), .overflow(overflow),
        .seg_n(seg_n), .dig_n(dig_n), .seg_all(seg_all)
    );

    seg7_scan_driver #(.DIGITS(3), .BIN_W(13), .SCAN_DIV(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .dp_in(dp2),
        .load(load), .blank_lz(blank_lz), .busy(busy2), .overflow(overflow2),
        .seg_n(seg_n2), .dig_n(dig_n2), .seg_all(seg_all2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse load for one cycle, then count cycles with busy high (bounded).
    task automatic do_load(input logic [12:0] v, input logic [3:0] dp,
                           input logic blz, input logic [2:0] d2);
        @(negedge clk);
        bin_in = v; dp_in = dp; dp2 = d2; blank_lz = blz; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        chk("idle_after_load", 64'(busy), 64'(0));
    endtask

    task automatic wait_dig(input logic [3:0] target, input string tag);
        int n = 0;
        while (dig_n !== target && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(dig_n), 64'(target));
    endtask

    logic [3:0] exp_dig [0:3];
    logic [7:0] exp_seg [0:3];

    initial begin
        exp_dig[0] = 4'b1110; exp_seg[0] = 8'h99;
        exp_dig[1] = 4'b1101; exp_seg[1] = 8'hB0;
        exp_dig[2] = 4'b1011; exp_seg[2] = 8'hA4;
        exp_dig[3] = 4'b0111; exp_seg[3] = 8'hF9;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_seg_n", 64'(seg_n), 64'hFF);
        chk("rst_dig_n", 64'(dig_n), 64'hF);
        chk("rst_seg_all", 64'(seg_all), 64'hFFFFFFFF);

        // First slot appears SCAN_DIV edges after release
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("scan_pre_first", 64'(dig_n), 64'hF);
        @(negedge clk);
        chk("scan_first_dig", 64'(dig_n), 64'(4'b1110));
        chk("scan_first_seg", 64'(seg_n), 64'hFF);

        // 1234: latency and value
        do_load(13'd1234, 4'b0000, 1'b1, 3'b000);
        chk("busy_cycles", 64'(nb), 64'(14));
        chk("v1234", 64'(seg_all), 64'hF9A4B099);
        chk("v1234_ovf", 64'(overflow), 64'(0));

        // Scan order, 4 cycles per slot
        wait_dig(4'b0111, "scan_sync_a");
        wait_dig(4'b1110, "scan_sync_b");
        for (int c = 0; c < 16; c++) begin
            chk("scan_dig", 64'(dig_n), 64'(exp_dig[c/4]));
            chk("scan_seg", 64'(seg_n), 64'(exp_seg[c/4]));
            @(negedge clk);
        end

        // Leading-zero blanking
        do_load(13'd7, 4'b0000, 1'b1, 3'b000);
        chk("v7_blank", 64'(seg_all), 64'hFFFFFFD8);
        do_load(13'd7, 4'b0000, 1'b0, 3'b000);
        chk("v7_noblank", 64'(seg_all), 64'hC0C0C0D8);
        do_load(13'd0, 4'b0000, 1'b1, 3'b000);
        chk("v0_blank", 64'(seg_all), 64'hFFFFFFC0);

        // Max input: fits 4 digits, overflows 3 digits (dp still on dash)
        do_load(13'd8191, 4'b0000, 1'b1, 3'b001);
        chk("v8191_4d", 64'(seg_all), 64'h80F990F9);
        chk("v8191_4d_ovf", 64'(overflow), 64'(0));
        chk("v8191_3d", 64'(seg_all2), 64'hBFBF3F);
        chk("v8191_3d_ovf", 64'(overflow2), 64'(1));
        do_load(13'd10, 4'b0000, 1'b1, 3'b000);
        chk("v10_4d", 64'(seg_all), 64'hFFFFF9C0);
        chk("v10_3d", 64'(seg_all2), 64'hFFF9C0);
        chk("v10_3d_ovf", 64'(overflow2), 64'(0));
        do_load(13'd1000, 4'b0000, 1'b1, 3'b000);
        chk("v1000_3d", 64'(seg_all2), 64'hBFBFBF);
        chk("v1000_3d_ovf", 64'(overflow2), 64'(1));
        do_load(13'd999, 4'b0000, 1'b1, 3'b000);
        chk("v999_3d", 64'(seg_all2), 64'h909090);
        chk("v999_3d_ovf", 64'(overflow2), 64'(0));
        chk("v999_4d", 64'(seg_all), 64'hFF909090);

        // Decimal points, including on a blanked digit
        do_load(13'd1234, 4'b0100, 1'b1, 3'b000);
        chk("dp_1234", 64'(seg_all), 64'hF924B099);
        do_load(13'd5, 4'b0010, 1'b1, 3'b000);
        chk("dp_blank5", 64'(seg_all), 64'hFFFF7F92);

        // Load during busy is ignored
        @(negedge clk);
        bin_in = 13'd1234; dp_in = 4'b0000; blank_lz = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        bin_in = 13'd42; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        chk("ignore_idle", 64'(busy), 64'(0));
        chk("ignore_val", 64'(seg_all), 64'hF9A4B099);

        // Reset in the middle of a conversion
        @(negedge clk);
        bin_in = 13'd1234; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_seg_all", 64'(seg_all), 64'hFFFFFFFF);
        chk("midrst_dig_n", 64'(dig_n), 64'hF);
        chk("midrst_seg_n", 64'(seg_n), 64'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_load(13'd42, 4'b0000, 1'b1, 3'b000);
        chk("after_rst_42", 64'(seg_all), 64'hFFFF99A4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
